// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC coeff_token decoder.
//   mode_e       : decode mode chosen from nC (table 0, fixed-length, unsupported)
//   ct_result_t  : decoded result bundle {TotalCoeff, TrailingOnes, NumShift, Err}
//   s1_payload_t : stage-1 capture (saturated LZ, suffix after first 1, 6 MSBs, mode)
package cavlc_pkg;

   typedef enum logic [1:0] {
      MODE_T0  = 2'd0,
      MODE_FLC = 2'd1,
      MODE_BAD = 2'd2
   } mode_e;

   localparam int unsigned FLC_LEN       = 6;
   localparam int unsigned MAX_LZ        = 14;
   localparam logic [5:0]  FLC_ZERO_CODE = 6'b000011;

   localparam int unsigned TC_W  = 5;
   localparam int unsigned T1_W  = 2;
   localparam int unsigned NS_W  = 5;
   localparam int unsigned SUF_W = 4;
   // LZ is saturated to 4 bits: 0..14 are real codes, 15 stands for "more than 14"
   localparam int unsigned LZS_W = 4;
   localparam logic [LZS_W-1:0] LZ_OVER = 4'd15;

   typedef struct packed {
      logic [TC_W-1:0] total_coeff;
      logic [T1_W-1:0] trailing_ones;
      logic [NS_W-1:0] num_shift;
      logic            err;
   } ct_result_t;

   typedef struct packed {
      logic [LZS_W-1:0] lz;
      logic [SUF_W-1:0] suffix;
      logic [5:0]       msb6;
      mode_e            mode;
   } s1_payload_t;

   localparam ct_result_t CT_ERR = '{total_coeff: '0, trailing_ones: '0, num_shift: '0, err: 1'b1};

   // Build a valid (non-error) result
   function automatic ct_result_t ct_res(input logic [TC_W-1:0] tc,
                                         input logic [T1_W-1:0] t1,
                                         input logic [NS_W-1:0] ns);
      ct_result_t r;
      r.total_coeff   = tc;
      r.trailing_ones = t1;
      r.num_shift     = ns;
      r.err           = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/coeff_token_t0_lut.sv
// Combinational coeff_token lookup for 0 <= nC < 2 (H.264 Table 9-5, first column).
//   i_lz     : leading-zero count, saturated (15 = more than 14 zeros)
//   i_suffix : the 4 bits following the first 1, MSB first, zero padded past the window
//   o_res    : TotalCoeff / TrailingOnes / NumShift / Err
module coeff_token_t0_lut
   import cavlc_pkg::*;
(
   input  logic [LZS_W-1:0] i_lz,
   input  logic [SUF_W-1:0] i_suffix,
   output ct_result_t       o_res
);

   // No code in this column carries more than 3 bits after its first 1
   logic w_unused_suffix;
   assign w_unused_suffix = i_suffix[0];

   always_comb begin
      o_res = CT_ERR;
      case (i_lz)
         4'd0: o_res = ct_res(5'd0, 2'd0, 5'd1);
         4'd1: o_res = ct_res(5'd1, 2'd1, 5'd2);
         4'd2: o_res = ct_res(5'd2, 2'd2, 5'd3);
         4'd3: begin
            if (i_suffix[3])      o_res = ct_res(5'd3, 2'd3, 5'd5);
            else if (i_suffix[2]) o_res = ct_res(5'd1, 2'd0, 5'd6);
            else                  o_res = ct_res(5'd2, 2'd1, 5'd6);
         end
         4'd4: begin
            if (i_suffix[3])      o_res = ct_res(5'd4, 2'd3, 5'd6);
            else if (i_suffix[2]) o_res = ct_res(5'd3, 2'd2, 5'd7);
            else                  o_res = ct_res(5'd5, 2'd3, 5'd7);
         end
         4'd5: begin
            case (i_suffix[3:2])
               2'b11: o_res = ct_res(5'd2, 2'd0, 5'd8);
               2'b10: o_res = ct_res(5'd3, 2'd1, 5'd8);
               2'b01: o_res = ct_res(5'd4, 2'd2, 5'd8);
               2'b00: o_res = ct_res(5'd6, 2'd3, 5'd8);
            endcase
         end
         4'd6: begin
            case (i_suffix[3:2])
               2'b11: o_res = ct_res(5'd3, 2'd0, 5'd9);
               2'b10: o_res = ct_res(5'd4, 2'd1, 5'd9);
               2'b01: o_res = ct_res(5'd5, 2'd2, 5'd9);
               2'b00: o_res = ct_res(5'd7, 2'd3, 5'd9);
            endcase
         end
         4'd7: begin
            case (i_suffix[3:2])
               2'b11: o_res = ct_res(5'd4, 2'd0, 5'd10);
               2'b10: o_res = ct_res(5'd5, 2'd1, 5'd10);
               2'b01: o_res = ct_res(5'd6, 2'd2, 5'd10);
               2'b00: o_res = ct_res(5'd8, 2'd3, 5'd10);
            endcase
         end
         4'd8: begin
            case (i_suffix[3:2])
               2'b11: o_res = ct_res(5'd5, 2'd0, 5'd11);
               2'b10: o_res = ct_res(5'd6, 2'd1, 5'd11);
               2'b01: o_res = ct_res(5'd7, 2'd2, 5'd11);
               2'b00: o_res = ct_res(5'd9, 2'd3, 5'd11);
            endcase
         end
         4'd9: begin
            case (i_suffix[3:1])
               3'b111: o_res = ct_res(5'd6,  2'd0, 5'd13);
               3'b110: o_res = ct_res(5'd7,  2'd1, 5'd13);
               3'b101: o_res = ct_res(5'd8,  2'd2, 5'd13);
               3'b100: o_res = ct_res(5'd10, 2'd3, 5'd13);
               3'b011: o_res = ct_res(5'd7,  2'd0, 5'd13);
               3'b010: o_res = ct_res(5'd8,  2'd1, 5'd13);
               3'b001: o_res = ct_res(5'd9,  2'd2, 5'd13);
               3'b000: o_res = ct_res(5'd8,  2'd0, 5'd13);
            endcase
         end
         4'd10: begin
            case (i_suffix[3:1])
               3'b111: o_res = ct_res(5'd9,  2'd0, 5'd14);
               3'b110: o_res = ct_res(5'd9,  2'd1, 5'd14);
               3'b101: o_res = ct_res(5'd10, 2'd2, 5'd14);
               3'b100: o_res = ct_res(5'd11, 2'd3, 5'd14);
               3'b011: o_res = ct_res(5'd10, 2'd0, 5'd14);
               3'b010: o_res = ct_res(5'd10, 2'd1, 5'd14);
               3'b001: o_res = ct_res(5'd11, 2'd2, 5'd14);
               3'b000: o_res = ct_res(5'd12, 2'd3, 5'd14);
            endcase
         end
         4'd11: begin
            case (i_suffix[3:1])
               3'b111: o_res = ct_res(5'd11, 2'd0, 5'd15);
               3'b110: o_res = ct_res(5'd11, 2'd1, 5'd15);
               3'b101: o_res = ct_res(5'd12, 2'd2, 5'd15);
               3'b100: o_res = ct_res(5'd13, 2'd3, 5'd15);
               3'b011: o_res = ct_res(5'd12, 2'd0, 5'd15);
               3'b010: o_res = ct_res(5'd12, 2'd1, 5'd15);
               3'b001: o_res = ct_res(5'd13, 2'd2, 5'd15);
               3'b000: o_res = ct_res(5'd14, 2'd3, 5'd15);
            endcase
         end
         4'd12: begin
            case (i_suffix[3:1])
               3'b111: o_res = ct_res(5'd13, 2'd0, 5'd16);
               3'b110: o_res = ct_res(5'd14, 2'd1, 5'd16);
               3'b101: o_res = ct_res(5'd14, 2'd2, 5'd16);
               3'b100: o_res = ct_res(5'd15, 2'd3, 5'd16);
               3'b011: o_res = ct_res(5'd14, 2'd0, 5'd16);
               3'b010: o_res = ct_res(5'd15, 2'd1, 5'd16);
               3'b001: o_res = ct_res(5'd15, 2'd2, 5'd16);
               3'b000: o_res = ct_res(5'd16, 2'd3, 5'd16);
            endcase
         end
         4'd13: begin
            case (i_suffix[3:2])
               2'b11: o_res = ct_res(5'd15, 2'd0, 5'd16);
               2'b10: o_res = ct_res(5'd16, 2'd1, 5'd16);
               2'b01: o_res = ct_res(5'd16, 2'd2, 5'd16);
               2'b00: o_res = ct_res(5'd16, 2'd0, 5'd16);
            endcase
         end
         4'd14:   o_res = ct_res(5'd13, 2'd1, 5'd15);
         default: o_res = CT_ERR;
      endcase
   end

endmodule

// File: rtl/coeff_token_decoder.sv
// Two-stage pipelined CAVLC coeff_token decoder with valid/ready flow control.
//   Clk, nReset            : clock, asynchronous active-low reset
//   InValid/InReady        : input handshake (InReady is combinational from OutReady)
//   Bits                   : left-aligned bitstream window, MSB = next bit
//   nC                     : signed nC; 0..1 table 0, >=8 fixed-length, else error
//   OutValid/OutReady      : output handshake
//   TotalCoeff, TrailingOnes, NumShift, Err : registered decode result
module coeff_token_decoder
   import cavlc_pkg::*;
#(
   parameter int unsigned WIN_W = 16,
   parameter int unsigned NC_W  = 5
) (
   input  logic              Clk,
   input  logic              nReset,
   input  logic              InValid,
   output logic              InReady,
   input  logic [WIN_W-1:0]  Bits,
   input  logic [NC_W-1:0]   nC,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [TC_W-1:0]   TotalCoeff,
   output logic [T1_W-1:0]   TrailingOnes,
   output logic [NS_W-1:0]   NumShift,
   output logic              Err
);

   localparam int unsigned LZ_W = $clog2(WIN_W + 1);

   logic             r_s1_valid;
   s1_payload_t      r_s1;
   logic             r_s2_valid;
   ct_result_t       r_res;

   logic             w_s2_load;
   logic             w_s1_adv;
   logic             w_s1_load;
   logic             w_in_xfer;
   logic [LZ_W-1:0]  w_lz;
   logic [LZS_W-1:0] w_lz_sat;
   logic [SUF_W-1:0] w_suffix;
   mode_e            w_mode;
   s1_payload_t      w_s1_next;
   ct_result_t       w_t0_res;
   ct_result_t       w_res;
   logic [TC_W-1:0]  w_flc_tc;
   logic [T1_W-1:0]  w_flc_t1;

   // Handshake: each stage refills as soon as its occupant moves on
   assign w_s2_load = !r_s2_valid || OutReady;
   assign w_s1_adv  = r_s1_valid && w_s2_load;
   assign w_s1_load = !r_s1_valid || w_s1_adv;
   assign w_in_xfer = InValid && w_s1_load;
   assign InReady   = w_s1_load;

   // Leading-zero count: last hit in an LSB-to-MSB scan is the first 1 in the stream
   always_comb begin
      w_lz = LZ_W'(WIN_W);
      for (int i = 0; i < WIN_W; i++) begin
         if (Bits[i]) w_lz = LZ_W'(WIN_W - 1 - i);
      end
   end

   assign w_lz_sat = (w_lz > LZ_W'(MAX_LZ)) ? LZ_OVER : LZS_W'(w_lz);

   // Shift the first 1 to the top of a zero-padded copy; the next 4 bits are the suffix
   assign w_suffix = SUF_W'(({Bits, {SUF_W{1'b0}}} << w_lz) >> (WIN_W - 1));

   // Mode from nC: negative or 2..7 are unsupported
   always_comb begin
      w_mode = MODE_BAD;
      if (!nC[NC_W-1]) begin
         if (nC < NC_W'(2))       w_mode = MODE_T0;
         else if (nC >= NC_W'(8)) w_mode = MODE_FLC;
      end
   end

   assign w_s1_next = '{lz: w_lz_sat, suffix: w_suffix, msb6: Bits[WIN_W-1 -: 6], mode: w_mode};

   coeff_token_t0_lut u_t0_lut (
      .i_lz     (r_s1.lz),
      .i_suffix (r_s1.suffix),
      .o_res    (w_t0_res)
   );

   // Fixed-length code xxxxyy: TotalCoeff = xxxx+1, TrailingOnes = yy
   assign w_flc_tc = TC_W'(r_s1.msb6[5:2]) + TC_W'(1);
   assign w_flc_t1 = r_s1.msb6[1:0];

   // Stage-2 result select
   always_comb begin
      w_res = CT_ERR;
      case (r_s1.mode)
         MODE_T0:  w_res = w_t0_res;
         MODE_FLC: begin
            if (r_s1.msb6 == FLC_ZERO_CODE)
               w_res = ct_res(TC_W'(0), T1_W'(0), NS_W'(FLC_LEN));
            else if (TC_W'(w_flc_t1) > w_flc_tc)
               w_res = CT_ERR;
            else
               w_res = ct_res(w_flc_tc, w_flc_t1, NS_W'(FLC_LEN));
         end
         default:  w_res = CT_ERR;
      endcase
   end

   // Pipeline registers; result data only changes when a token enters stage 2
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
         r_s2_valid <= 1'b0;
         r_res      <= '0;
      end else begin
         if (w_s1_load) r_s1_valid <= InValid;
         if (w_in_xfer) r_s1       <= w_s1_next;
         if (w_s2_load) r_s2_valid <= r_s1_valid;
         if (w_s1_adv)  r_res      <= w_res;
      end
   end

   assign OutValid     = r_s2_valid;
   assign TotalCoeff   = r_res.total_coeff;
   assign TrailingOnes = r_res.trailing_ones;
   assign NumShift     = r_res.num_shift;
   assign Err          = r_res.err;

endmodule

// File: tb/tb_coeff_token_decoder.sv
// Directed self-checking bench for coeff_token_decoder.
module tb_coeff_token_decoder;

   logic        Clk = 1'b0;
   logic        nReset;
   logic        InValid;
   logic        InReady;
   logic [15:0] Bits;
   logic [4:0]  nC;
   logic        OutValid;
   logic        OutReady;
   logic [4:0]  TotalCoeff;
   logic [1:0]  TrailingOnes;
   logic [4:0]  NumShift;
   logic        Err;
   logic [12:0] w_obs;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [12:0] EX_ERR = 13'h0001;

   always #5 Clk = ~Clk;

   coeff_token_decoder #(.WIN_W(16), .NC_W(5)) dut (
      .Clk          (Clk),
      .nReset       (nReset),
      .InValid      (InValid),
      .InReady      (InReady),
      .Bits         (Bits),
      .nC           (nC),
      .OutValid     (OutValid),
      .OutReady     (OutReady),
      .TotalCoeff   (TotalCoeff),
      .TrailingOnes (TrailingOnes),
      .NumShift     (NumShift),
      .Err          (Err)
   );

   assign w_obs = {TotalCoeff, TrailingOnes, NumShift, Err};

   // Packs an expected {TC, T1s, len, err} tuple
   function automatic logic [12:0] ex(input int tc, input int t1, input int ns, input bit e);
      return {5'(tc), 2'(t1), 5'(ns), e};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic flush();
      InValid  = 1'b0;
      OutReady = 1'b1;
      repeat (3) tick();
   endtask

   // One token in, then wait until it sits in the output register
   task automatic send_one(input logic [15:0] b, input logic [4:0] nc);
      Bits    = b;
      nC      = nc;
      InValid = 1'b1;
      tick();
      InValid = 1'b0;
      Bits    = ~b;
      nC      = 5'd3;
      tick();
   endtask

   task automatic test_reset();
      nReset   = 1'b0;
      InValid  = 1'b0;
      OutReady = 1'b1;
      Bits     = 16'h0;
      nC       = 5'd0;
      #3;
      n_vec++;
      if (OutValid !== 1'b0) begin n_err++; $display("FAIL reset_outvalid: got %b want 0", OutValid); end
      n_vec++;
      if (w_obs !== 13'h0) begin n_err++; $display("FAIL reset_fields: got %h want 0000", w_obs); end
      n_vec++;
      if (InReady !== 1'b1) begin n_err++; $display("FAIL reset_inready: got %b want 1", InReady); end
      repeat (2) tick();
      nReset = 1'b1;
      tick();
      n_vec++;
      if (OutValid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got %b want 0", OutValid); end
   endtask

   task automatic test_t0();
      logic [15:0] vb [14] = '{16'h8000, 16'hFFFF, 16'h4000, 16'h2000, 16'h1800, 16'h1400, 16'h17FF,
                               16'h1000, 16'h0C00, 16'h0700, 16'h0068, 16'h0008, 16'h0004, 16'h0003};
      logic [4:0]  vn [14] = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                               5'd0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0};
      logic [12:0] ve [14] = '{ex(0,0,1,0), ex(0,0,1,0), ex(1,1,2,0), ex(2,2,3,0), ex(3,3,5,0),
                               ex(1,0,6,0), ex(1,0,6,0), ex(2,1,6,0), ex(4,3,6,0), ex(2,0,8,0),
                               ex(8,2,13,0), ex(16,3,16,0), ex(16,0,16,0), ex(13,1,15,0)};
      flush();
      for (int i = 0; i < 14; i++) begin
         send_one(vb[i], vn[i]);
         n_vec++;
         if (OutValid !== 1'b1 || w_obs !== ve[i]) begin
            n_err++;
            $display("FAIL t0[%0d] bits=%h: got valid=%b res=%h want valid=1 res=%h", i, vb[i], OutValid, w_obs, ve[i]);
         end
      end
   endtask

   task automatic test_flc();
      logic [15:0] vb [9] = '{16'h0C00, 16'h0FFF, 16'h2800, 16'hFC00, 16'h0000,
                              16'h0400, 16'h0800, 16'h1C00, 16'h0BFF};
      logic [4:0]  vn [9] = '{5'd8, 5'd8, 5'd8, 5'd15, 5'd15, 5'd8, 5'd8, 5'd8, 5'd8};
      logic [12:0] ve [9] = '{ex(0,0,6,0), ex(0,0,6,0), ex(3,2,6,0), ex(16,3,6,0), ex(1,0,6,0),
                              ex(1,1,6,0), EX_ERR, EX_ERR, EX_ERR};
      flush();
      for (int i = 0; i < 9; i++) begin
         send_one(vb[i], vn[i]);
         n_vec++;
         if (OutValid !== 1'b1 || w_obs !== ve[i]) begin
            n_err++;
            $display("FAIL flc[%0d] bits=%h: got valid=%b res=%h want valid=1 res=%h", i, vb[i], OutValid, w_obs, ve[i]);
         end
      end
   endtask

   task automatic test_bad();
      logic [15:0] vb [8] = '{16'h8000, 16'h4000, 16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'h0001, 16'h8000};
      logic [4:0]  vn [8] = '{5'h1F, 5'd0, 5'd4, 5'd0, 5'd2, 5'd7, 5'd0, 5'h10};
      logic [12:0] ve [8] = '{EX_ERR, ex(1,1,2,0), EX_ERR, EX_ERR, EX_ERR, EX_ERR, EX_ERR, EX_ERR};
      flush();
      for (int i = 0; i < 8; i++) begin
         send_one(vb[i], vn[i]);
         n_vec++;
         if (OutValid !== 1'b1 || w_obs !== ve[i]) begin
            n_err++;
            $display("FAIL bad[%0d] nc=%h: got valid=%b res=%h want valid=1 res=%h", i, vn[i], OutValid, w_obs, ve[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] vb [8] = '{16'h8000, 16'h0C00, 16'h2800, 16'h8000, 16'h4000, 16'h0068, 16'h0000, 16'hFC00};
      logic [4:0]  vn [8] = '{5'd0, 5'd0, 5'd8, 5'h1F, 5'd1, 5'd0, 5'd0, 5'd8};
      logic [12:0] ve [8] = '{ex(0,0,1,0), ex(4,3,6,0), ex(3,2,6,0), EX_ERR,
                              ex(1,1,2,0), ex(8,2,13,0), EX_ERR, ex(16,3,6,0)};
      logic exp_v;
      flush();
      for (int step = 0; step <= 10; step++) begin
         InValid = (step < 8);
         if (step < 8) begin
            Bits = vb[step];
            nC   = vn[step];
         end
         #1;
         exp_v = (step >= 2 && step <= 9);
         n_vec++;
         if (OutValid !== exp_v) begin
            n_err++;
            $display("FAIL b2b_valid step %0d: got %b want %b", step, OutValid, exp_v);
         end
         if (exp_v) begin
            n_vec++;
            if (w_obs !== ve[step-2]) begin
               n_err++;
               $display("FAIL b2b_data step %0d: got %h want %h", step, w_obs, ve[step-2]);
            end
         end
         if (step < 8) begin
            n_vec++;
            if (InReady !== 1'b1) begin n_err++; $display("FAIL b2b_inready step %0d: got %b want 1", step, InReady); end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] vb [6] = '{16'h1400, 16'h2000, 16'h0C00, 16'h0800, 16'h0700, 16'h0003};
      logic [4:0]  vn [6] = '{5'd0, 5'd0, 5'd8, 5'd8, 5'd1, 5'd0};
      logic [12:0] ve [6] = '{ex(1,0,6,0), ex(2,2,3,0), ex(0,0,6,0), EX_ERR, ex(2,0,8,0), ex(13,1,15,0)};
      int si = 0;
      int ri = 0;
      logic exp_rdy;
      logic exp_v;
      flush();
      for (int step = 0; step <= 12; step++) begin
         OutReady = (step >= 5);
         InValid  = (si < 6);
         if (si < 6) begin
            Bits = vb[si];
            nC   = vn[si];
         end
         #1;
         exp_rdy = (step < 2) || (step >= 5);
         exp_v   = (step >= 2 && step <= 10);
         n_vec++;
         if (InReady !== exp_rdy) begin
            n_err++;
            $display("FAIL bp_inready step %0d: got %b want %b", step, InReady, exp_rdy);
         end
         n_vec++;
         if (OutValid !== exp_v) begin
            n_err++;
            $display("FAIL bp_valid step %0d: got %b want %b", step, OutValid, exp_v);
         end
         if (OutValid === 1'b1 && ri < 6) begin
            n_vec++;
            if (w_obs !== ve[ri]) begin
               n_err++;
               $display("FAIL bp_data step %0d idx %0d: got %h want %h", step, ri, w_obs, ve[ri]);
            end
         end
         if (InValid && InReady === 1'b1) si++;
         if (OutValid === 1'b1 && OutReady) ri++;
         tick();
      end
      n_vec++;
      if (si != 6 || ri != 6) begin
         n_err++;
         $display("FAIL bp_count: got sent=%0d received=%0d want 6/6", si, ri);
      end
   endtask

   task automatic test_reset_midstream();
      flush();
      Bits    = 16'h1400;
      nC      = 5'd0;
      InValid = 1'b1;
      tick();
      Bits    = 16'h0C00;
      nC      = 5'd8;
      tick();
      InValid = 1'b0;
      n_vec++;
      if (OutValid !== 1'b1 || w_obs !== ex(1,0,6,0)) begin
         n_err++;
         $display("FAIL rst_pre: got valid=%b res=%h want valid=1 res=%h", OutValid, w_obs, ex(1,0,6,0));
      end
      nReset = 1'b0;
      #1;
      n_vec++;
      if (OutValid !== 1'b0 || w_obs !== 13'h0) begin
         n_err++;
         $display("FAIL rst_async: got valid=%b res=%h want valid=0 res=0000", OutValid, w_obs);
      end
      repeat (2) tick();
      nReset = 1'b1;
      tick();
      n_vec++;
      if (OutValid !== 1'b0) begin n_err++; $display("FAIL rst_stale: got valid=%b want 0", OutValid); end
      send_one(16'h0068, 5'd0);
      n_vec++;
      if (OutValid !== 1'b1 || w_obs !== ex(8,2,13,0)) begin
         n_err++;
         $display("FAIL rst_post: got valid=%b res=%h want valid=1 res=%h", OutValid, w_obs, ex(8,2,13,0));
      end
   endtask

   initial begin
      test_reset();
      test_t0();
      test_flc();
      test_bad();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench still running at time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
